// File: rtl/systolic_setup_pkg.sv
// Shared constants and the per-lane control tuple for the systolic input skew stage.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package systolic_setup_pkg;

  localparam int SYS_DIM    = 8;
  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 10;

  // Control tuple carried alongside each operand down a skew lane.
  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/systolic_setup_skew.sv
// DEPTH x WIDTH shift register with async reset; DEPTH=0 is a plain wire.
// Latency: DEPTH cycles.
// Backpressure: none, shifts every cycle.
module skew_delay #(
  parameter int DEPTH   = 1,
  parameter int WIDTH   = 1,
  parameter int VLD_BIT = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic             any_vld_o
);

  if (DEPTH == 0) begin : g_pass
    // Clock and reset are intentionally unused in the zero-depth case.
    logic w_unused;
    assign w_unused  = clk_i ^ rst_ni;
    assign q_o       = d_i;
    assign any_vld_o = 1'b0;
  end else begin : g_shift
    logic [WIDTH-1:0] r_pipe [DEPTH];

    // Shift the tuple one stage per cycle; reset drops everything in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
      end else begin
        r_pipe[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
      end
    end

    // Report whether any stored stage still holds a valid token.
    always_comb begin
      any_vld_o = 1'b0;
      for (int i = 0; i < DEPTH; i++) any_vld_o = any_vld_o | r_pipe[i][VLD_BIT];
    end

    assign q_o = r_pipe[DEPTH-1];
  end

endmodule

// File: rtl/systolic_setup.sv
// Aligns batch flags with buffer read data and skews lane j by j cycles into the array edge.
// Latency: RD_LAT+j for lane j (+1 with SYSTOLIC_SETUP_OUTREG_EN defined).
// Backpressure: none; the array consumes every cycle and this block never stalls.
module systolic_setup #(
  parameter int SYS_DIM    = systolic_setup_pkg::SYS_DIM,
  parameter int DATA_WIDTH = systolic_setup_pkg::DATA_WIDTH,
  parameter int RD_LAT     = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          ensys_i,
  input  logic                          bubble_i,
  input  logic                          batch_begin_i,
  input  logic                          batch_end_i,
  input  logic [SYS_DIM*DATA_WIDTH-1:0] data_i,
  output logic [SYS_DIM*DATA_WIDTH-1:0] data_o,
  output logic [SYS_DIM-1:0]            valid_o,
  output logic [SYS_DIM-1:0]            first_o,
  output logic [SYS_DIM-1:0]            last_o,
  output logic                          busy_o
);
  import systolic_setup_pkg::*;

  localparam int LANE_W = DATA_WIDTH + CTRL_W;
  localparam int BUS_W  = SYS_DIM * DATA_WIDTH;

  // Control pipe tuple: {ensys, bubble, begin, end}; ensys is the valid bit.
  logic [3:0] w_ctrl_in;
  logic [3:0] w_ctrl_al;
  logic       w_ctrl_busy;

  assign w_ctrl_in = {ensys_i, bubble_i, batch_begin_i, batch_end_i};

  skew_delay #(.DEPTH(RD_LAT), .WIDTH(4), .VLD_BIT(3)) u_ctrl_pipe (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .d_i       (w_ctrl_in),
    .q_o       (w_ctrl_al),
    .any_vld_o (w_ctrl_busy)
  );

  ctrl_t            w_s0_ctl;
  logic [BUS_W-1:0] w_s0_dat;

  // Stage 0: merge aligned flags with the read word; idle slots are masked, bubbles zeroed.
  always_comb begin
    w_s0_ctl = '0;
    w_s0_dat = '0;
    if (w_ctrl_al[3]) begin
      w_s0_ctl.valid = 1'b1;
      w_s0_ctl.first = w_ctrl_al[1];
      w_s0_ctl.last  = w_ctrl_al[0];
      if (!w_ctrl_al[2]) w_s0_dat = data_i;
    end
  end

  logic [LANE_W-1:0]  w_lane_q [SYS_DIM];
  logic [SYS_DIM-1:0] w_lane_busy;
  logic [BUS_W-1:0]   w_dat;
  logic [SYS_DIM-1:0] w_vld;
  logic [SYS_DIM-1:0] w_fst;
  logic [SYS_DIM-1:0] w_lst;

  for (genvar j = 0; j < SYS_DIM; j++) begin : g_lane
    ctrl_t w_ctl;

    skew_delay #(.DEPTH(j), .WIDTH(LANE_W), .VLD_BIT(CTRL_W-1)) u_dly (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .d_i       ({w_s0_dat[j*DATA_WIDTH +: DATA_WIDTH], w_s0_ctl}),
      .q_o       (w_lane_q[j]),
      .any_vld_o (w_lane_busy[j])
    );

    // Lane data is forced to zero whenever the lane is not valid.
    assign w_ctl                          = w_lane_q[j][CTRL_W-1:0];
    assign w_vld[j]                       = w_ctl.valid;
    assign w_fst[j]                       = w_ctl.first;
    assign w_lst[j]                       = w_ctl.last;
    assign w_dat[j*DATA_WIDTH +: DATA_WIDTH] =
      w_ctl.valid ? w_lane_q[j][LANE_W-1:CTRL_W] : '0;
  end

`ifdef SYSTOLIC_SETUP_OUTREG_EN
  logic [BUS_W-1:0]   r_dat;
  logic [SYS_DIM-1:0] r_vld;
  logic [SYS_DIM-1:0] r_fst;
  logic [SYS_DIM-1:0] r_lst;

  // Retime the already-gated outputs by one cycle for timing closure at the array edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_dat <= '0;
      r_vld <= '0;
      r_fst <= '0;
      r_lst <= '0;
    end else begin
      r_dat <= w_dat;
      r_vld <= w_vld;
      r_fst <= w_fst;
      r_lst <= w_lst;
    end
  end

  assign data_o  = r_dat;
  assign valid_o = r_vld;
  assign first_o = r_fst;
  assign last_o  = r_lst;
  assign busy_o  = w_ctrl_busy | (|w_lane_busy) | (|r_vld);
`else
  assign data_o  = w_dat;
  assign valid_o = w_vld;
  assign first_o = w_fst;
  assign last_o  = w_lst;
  // Stage 0 valid is the last control-pipe register, so it is covered by w_ctrl_busy.
  assign busy_o  = w_ctrl_busy | (|w_lane_busy);
`endif

endmodule

// File: tb/tb_systolic_setup.sv
// Randomized self-checking bench for systolic_setup against a cycle-history reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_systolic_setup;

  localparam int SD  = 8;
  localparam int DW  = 16;
  localparam int RL  = 1;
  localparam int W   = SD * DW;
  localparam int NH  = 8192;
`ifdef SYSTOLIC_SETUP_OUTREG_EN
  localparam int OUT = 1;
`else
  localparam int OUT = 0;
`endif
  localparam int OFF = RL + OUT;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en, bub, bg, nd;
  logic [W-1:0]  din;
  logic [W-1:0]  data_o;
  logic [SD-1:0] valid_o, first_o, last_o;
  logic          busy_o;

  always #5 clk = ~clk;

  systolic_setup #(.SYS_DIM(SD), .DATA_WIDTH(DW), .RD_LAT(RL)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .ensys_i       (en),
    .bubble_i      (bub),
    .batch_begin_i (bg),
    .batch_end_i   (nd),
    .data_i        (din),
    .data_o        (data_o),
    .valid_o       (valid_o),
    .first_o       (first_o),
    .last_o        (last_o),
    .busy_o        (busy_o)
  );

  typedef struct {
    logic         en;
    logic         bub;
    logic         bg;
    logic         nd;
    logic [W-1:0] d;
  } in_t;

  in_t           hist  [0:NH-1];
  logic [SD-1:0] o_vld [0:NH-1];
  logic [SD-1:0] o_fst [0:NH-1];
  logic [SD-1:0] o_lst [0:NH-1];
  logic          o_busy[0:NH-1];

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_word();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [W-1:0] pat(input int c);
    logic [W-1:0] r;
    for (int j = 0; j < SD; j++) r[j*DW +: DW] = DW'(c * 256 + j);
    return r;
  endfunction

  // Reference: the token issued at cycle s reaches lane j at s+OFF+j, carrying
  // the read word that arrived RL cycles after issue; busy spans issue+1 .. issue+OFF+SD-1.
  task automatic compare_model();
    logic [W-1:0]  e_d;
    logic [SD-1:0] e_v, e_f, e_l;
    logic          e_b;
    e_d = '0; e_v = '0; e_f = '0; e_l = '0; e_b = 1'b0;
    for (int j = 0; j < SD; j++) begin
      int s;
      s = cyc - OFF - j;
      if (s >= 0 && hist[s].en) begin
        e_v[j] = 1'b1;
        e_f[j] = hist[s].bg;
        e_l[j] = hist[s].nd;
        if (!hist[s].bub) e_d[j*DW +: DW] = hist[s+RL].d[j*DW +: DW];
      end
    end
    for (int s = cyc - OFF - SD + 1; s < cyc; s++)
      if (s >= 0 && hist[s].en) e_b = 1'b1;
    check_eq("data_o",  128'(data_o),  128'(e_d));
    check_eq("valid_o", 128'(valid_o), 128'(e_v));
    check_eq("first_o", 128'(first_o), 128'(e_f));
    check_eq("last_o",  128'(last_o),  128'(e_l));
    check_eq("busy_o",  128'(busy_o),  128'(e_b));
  endtask

  task automatic step(input logic e, input logic b, input logic g, input logic n,
                      input logic [W-1:0] d);
    if (cyc >= NH - 2) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, NH - 2);
      $fatal(1, "cycle budget exhausted");
    end
    en = e; bub = b; bg = g; nd = n; din = d;
    hist[cyc].en  = rst_n & e;
    hist[cyc].bub = b;
    hist[cyc].bg  = g;
    hist[cyc].nd  = n;
    hist[cyc].d   = d;
    if (!rst_n)
      for (int i = 0; i <= cyc; i++) hist[i].en = 1'b0;
    @(negedge clk);
    compare_model();
    o_vld[cyc]  = valid_o;
    o_fst[cyc]  = first_o;
    o_lst[cyc]  = last_o;
    o_busy[cyc] = busy_o;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), rnd_word());
  endtask

  task automatic lane_stats(input int c_from, input int c_to, input int lane,
                            output int nv, output int nf, output int nl,
                            output int span, output int fpos);
    int last_c;
    nv = 0; nf = 0; nl = 0; fpos = -1; last_c = -1;
    for (int c = c_from; c <= c_to; c++) begin
      if (o_vld[c][lane]) begin
        nv++;
        if (fpos < 0) fpos = c;
        last_c = c;
      end
      nf += int'(o_fst[c][lane]);
      nl += int'(o_lst[c][lane]);
    end
    span = (fpos < 0) ? 0 : last_c - fpos + 1;
  endtask

  // Single k=8 batch with the cycle-stamped data pattern plus timing/count checks.
  task automatic run_pat_batch(input string tag);
    int c0, fall, nv, nf, nl, sp, fp;
    c0 = cyc;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, i == 0, i == 7, pat(cyc));
    for (int i = 0; i < 24; i++) step(1'b0, 1'b0, 1'b0, 1'b0, pat(cyc));
    fall = -1;
    for (int c = c0 + 1; c < cyc; c++)
      if (fall < 0 && o_busy[c-1] && !o_busy[c]) fall = c;
    check_eq({tag, "_busy_fall"}, 128'(fall - c0), 128'(8 + RL + SD - 1 + OUT));
    for (int k = 0; k < 2; k++) begin
      int lane;
      lane = (k == 0) ? 0 : SD - 1;
      lane_stats(c0, cyc - 1, lane, nv, nf, nl, sp, fp);
      check_eq({tag, "_nvalid"}, 128'(nv), 128'(8));
      check_eq({tag, "_nfirst"}, 128'(nf), 128'(1));
      check_eq({tag, "_nlast"},  128'(nl), 128'(1));
      check_eq({tag, "_first_pos"}, 128'(fp - c0), 128'(OFF + lane));
    end
  endtask

  initial begin
    int c0, nv, nf, nl, sp, fp;
    rst_n = 1'b0; en = 1'b0; bub = 1'b0; bg = 1'b0; nd = 1'b0; din = '0;
    #1;

    // Reset held with random inputs, then a quiet idle period.
    for (int i = 0; i < 5; i++)
      step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), rnd_word());
    rst_n = 1'b1;
    idle(20);

    // Single full batch.
    run_pat_batch("single");

    // Bubble padding: k=3 inside a batch of 8.
    for (int i = 0; i < 8; i++) step(1'b1, i >= 3, i == 0, i == 7, rnd_word());
    idle(20);

    // Four back-to-back batches of 8.
    c0 = cyc;
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, i == 0, i == 7, rnd_word());
    idle(20);
    for (int k = 0; k < 2; k++) begin
      int lane;
      lane = (k == 0) ? 0 : SD - 1;
      lane_stats(c0, cyc - 1, lane, nv, nf, nl, sp, fp);
      check_eq("b2b_nvalid", 128'(nv), 128'(32));
      check_eq("b2b_span",   128'(sp), 128'(32));
      check_eq("b2b_nfirst", 128'(nf), 128'(4));
      check_eq("b2b_nlast",  128'(nl), 128'(4));
    end

    // Reset in the middle of a batch, then a fresh batch.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, i == 0, 1'b0, rnd_word());
    rst_n = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0, rnd_word());
    step(1'b1, 1'b0, 1'b0, 1'b1, rnd_word());
    rst_n = 1'b1;
    idle(5);
    run_pat_batch("post_rst");

    // Random batches: random length, bubble count and inter-batch gap.
    for (int b = 0; b < 30; b++) begin
      int len, k, gap;
      len = $urandom_range(1, 12);
      k   = $urandom_range(0, len);
      gap = $urandom_range(0, 3);
      for (int i = 0; i < len; i++)
        step(1'b1, i >= k, i == 0, i == len - 1, rnd_word());
      idle(gap);
    end
    idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
